// File: rtl/uart_communication_if.sv
// Controller-side handshake bundle for uart_communication: byte, START/STOP level
// controls, serial line and busy flag.
interface uart_communication_if;
    logic       START;
    logic       STOP;
    logic [7:0] SW;
    logic       UART_TXD;
    logic       TX_BUSY_REG;

    modport master (output START, STOP, SW, input UART_TXD, TX_BUSY_REG);
    modport slave  (input START, STOP, SW, output UART_TXD, TX_BUSY_REG);
endinterface

// File: rtl/uart_communication.sv
// Byte-wide UART transmitter (8N1, LSB first) with a minimum idle gap between frames.
// Define UART_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_communication #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int IDLE_GAP_CYCLES = 4
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    uart_communication_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int GAP_W  = (IDLE_GAP_CYCLES > 1) ? $clog2(IDLE_GAP_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP_BIT,
        GAP
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              baud_wrap;
`ifdef UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE && state_q != GAP) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (bus.START && !bus.STOP) begin
                    state_d = START_BIT;
                    shift_d = bus.SW;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef UART_PARITY_EN
                    parity_d = ^bus.SW;
`endif
                end
            end
            START_BIT: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                // shift_q[0] is the bit on the line; shift_q[1] is the next one out
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP_BIT;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_wrap) begin
                    state_d = STOP_BIT;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP_BIT: begin
                if (baud_wrap) begin
                    state_d = GAP;
                    busy_d  = 1'b0;
                    txd_d   = 1'b1;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.UART_TXD    = txd_q;
    assign bus.TX_BUSY_REG = busy_q;
endmodule

// File: tb/tb_uart_communication.sv
// Self-checking bench for uart_communication: frame-level reference model compared every
// cycle, plus directed scenarios with hand-computed frame contents and timings.
module tb_uart_communication;
    localparam int CPB = 4;
    localparam int GAP = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    uart_communication_if bus();

    uart_communication #(.CLKS_PER_BIT(CPB), .IDLE_GAP_CYCLES(GAP)) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a bit vector; the line shows bit (cycles_since_accept / CPB)
    int         m_pos = -1;
    int         m_gap = 0;
    logic [10:0] m_bits = '1;
    logic       exp_txd = 1'b1;
    logic       exp_busy = 1'b0;
    logic       model_on = 1'b0;

    always @(posedge clk) begin
        model_on = 1'b1;
        if (!rst_n) begin
            m_pos = -1; m_gap = 0; exp_txd = 1'b1; exp_busy = 1'b0;
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == NB * CPB) begin
                m_pos = -1; m_gap = GAP; exp_txd = 1'b1; exp_busy = 1'b0;
            end else begin
                exp_txd = m_bits[m_pos / CPB];
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.START && !bus.STOP) begin
            m_bits = '1;
            m_bits[0] = 1'b0;
            m_bits[8:1] = bus.SW;
`ifdef UART_PARITY_EN
            m_bits[9] = ^bus.SW;
`endif
            m_pos = 0; exp_txd = 1'b0; exp_busy = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_txd", int'(bus.UART_TXD), int'(exp_txd));
            chk("model_busy", int'(bus.TX_BUSY_REG), int'(exp_busy));
        end
    end

    // Called on the first busy cycle; samples mid-bit and measures busy length
    task automatic collect(output logic [10:0] fr, output int blen);
        fr = '1;
        blen = 0;
        while (bus.TX_BUSY_REG && blen < 400) begin
            if ((blen % CPB) == CPB / 2 && (blen / CPB) < 11) fr[blen / CPB] = bus.UART_TXD;
            blen++;
            @(negedge clk);
        end
    endtask

    task automatic wait_busy(input string name);
        int t = 0;
        while (!bus.TX_BUSY_REG && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(bus.TX_BUSY_REG), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] fr;
        int blen, low, hb;

        rst_n = 1'b0;
        bus.START = 1'b1;
        bus.STOP = 1'b0;
        bus.SW = 8'h5A;
        repeat (3) @(negedge clk);
        chk("reset_txd", int'(bus.UART_TXD), 1);
        chk("reset_busy", int'(bus.TX_BUSY_REG), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("accept_first_edge_busy", int'(bus.TX_BUSY_REG), 1);
        chk("accept_first_edge_txd", int'(bus.UART_TXD), 0);
        bus.START = 1'b0;
        repeat (NB * CPB + 10) @(negedge clk);

        // Single byte, one-cycle START pulse
        bus.SW = 8'hA5;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        chk("a5_accept", int'(bus.TX_BUSY_REG), 1);
        collect(fr, blen);
        chk("a5_busy_len", blen, NB * CPB);
        chk("a5_start_bit", int'(fr[0]), 0);
        chk("a5_data", int'(fr[8:1]), 8'hA5);
`ifndef UART_PARITY_EN
        chk("a5_line_seq", int'(fr[9:0]), 10'h34A);
`endif
        repeat (10) @(negedge clk);

        // Streaming with START held; SW updated one cycle after busy falls
        bus.SW = 8'h00;
        bus.START = 1'b1;
        wait_busy("stream_first_busy");
        collect(fr, blen);
        chk("stream_f1_data", int'(fr[8:1]), 8'h00);
        chk("stream_f1_len", blen, NB * CPB);
        low = 0;
        while (!bus.TX_BUSY_REG && low < 100) begin
            low++;
            if (low == 2) bus.SW = 8'hFF;
            @(negedge clk);
        end
        chk("stream_gap_low", low, 5);
        collect(fr, blen);
        bus.START = 1'b0;
        chk("stream_f2_data", int'(fr[8:1]), 8'hFF);
        chk("stream_f2_stop", int'(fr[NB-1]), 1);
        repeat (10) @(negedge clk);

        // START and STOP together in IDLE: no accept
        bus.START = 1'b1;
        bus.STOP = 1'b1;
        hb = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.TX_BUSY_REG) hb++;
        end
        chk("start_stop_same_edge", hb, 0);
        bus.STOP = 1'b0;
        bus.START = 1'b0;
        repeat (2) @(negedge clk);

        // STOP mid-frame: frame completes, nothing new until STOP drops
        bus.SW = 8'h81;
        bus.START = 1'b1;
        wait_busy("stop_first_busy");
        fork
            collect(fr, blen);
            begin
                repeat (15) @(negedge clk);
                bus.STOP = 1'b1;
            end
        join
        chk("stop_frame_len", blen, NB * CPB);
        chk("stop_frame_data", int'(fr[8:1]), 8'h81);
        hb = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.TX_BUSY_REG) hb++;
        end
        chk("stop_inhibit", hb, 0);
        bus.STOP = 1'b0;
        @(negedge clk);
        chk("stop_release_accept", int'(bus.TX_BUSY_REG), 1);
        collect(fr, blen);
        bus.START = 1'b0;
        chk("stop_release_data", int'(fr[8:1]), 8'h81);
        repeat (10) @(negedge clk);

        // Reset during data bit 3, then a clean frame
        bus.SW = 8'hF0;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        chk("rst_mid_accept", int'(bus.TX_BUSY_REG), 1);
        repeat (17) @(negedge clk);
        chk("rst_mid_bit3", int'(bus.UART_TXD), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_txd", int'(bus.UART_TXD), 1);
        chk("rst_mid_busy", int'(bus.TX_BUSY_REG), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.SW = 8'h3C;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        chk("post_rst_accept", int'(bus.TX_BUSY_REG), 1);
        collect(fr, blen);
        chk("post_rst_len", blen, NB * CPB);
        chk("post_rst_data", int'(fr[8:1]), 8'h3C);
        chk("post_rst_stop", int'(fr[NB-1]), 1);
        repeat (10) @(negedge clk);

`ifdef UART_PARITY_EN
        bus.SW = 8'h07;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        collect(fr, blen);
        chk("par07_len", blen, 44);
        chk("par07_bit", int'(fr[9]), 1);
        chk("par07_stop", int'(fr[10]), 1);
        repeat (10) @(negedge clk);
        bus.SW = 8'h03;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        collect(fr, blen);
        chk("par03_bit", int'(fr[9]), 0);
        repeat (10) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
